// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, result and ALU-side bus of alu_arbiter
interface alu_arbiter_if;
  logic        req0, req1;
  logic [5:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic        gnt0, gnt1;
  logic [31:0] res0, res1;
  logic        vld0, vld1;
  logic        busy;
  logic [5:0]  alu_op;
  logic [31:0] alu_inpt1, alu_inpt2;
  logic        alu_en;
  logic [31:0] alu_outpt;

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1, alu_outpt,
    output gnt0, gnt1, res0, res1, vld0, vld1, busy,
           alu_op, alu_inpt1, alu_inpt2, alu_en
  );

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1, alu_outpt,
    input  gnt0, gnt1, res0, res1, vld0, vld1, busy,
           alu_op, alu_inpt1, alu_inpt2, alu_en
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two ports
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last, owner;
  logic        g0, g1;
  logic [5:0]  op_q;
  logic [31:0] in1_q, in2_q;
  logic [31:0] res0_q, res1_q;
  logic        vld0_q, vld1_q;

  // On a tie, port !last wins; last resets to 1 so port 0 takes the first tie.
  always_comb begin
    g0        = 1'b0;
    g1        = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last)) g0 = 1'b1;
        else if (bus.req1)                   g1 = 1'b1;
        if (g0 || g1) state_nxt = EXEC;
      end
      EXEC: if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last   <= 1'b1;
      owner  <= 1'b0;
      op_q   <= 6'd0;
      in1_q  <= 32'd0;
      in2_q  <= 32'd0;
      res0_q <= 32'd0;
      res1_q <= 32'd0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (g0 || g1) begin
            op_q  <= g1 ? bus.op1 : bus.op0;
            in1_q <= g1 ? bus.a1  : bus.a0;
            in2_q <= g1 ? bus.b1  : bus.b0;
            owner <= g1;
            last  <= g1;
            cnt   <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (owner) begin
            res1_q <= bus.alu_outpt;
            vld1_q <= 1'b1;
          end else begin
            res0_q <= bus.alu_outpt;
            vld0_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.busy      = (state == EXEC);
  assign bus.alu_en    = (state == EXEC);
  assign bus.alu_op    = op_q;
  assign bus.alu_inpt1 = in1_q;
  assign bus.alu_inpt2 = in2_q;
  assign bus.res0      = res0_q;
  assign bus.res1      = res1_q;
  assign bus.vld0      = vld0_q;
  assign bus.vld1      = vld1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter at ALU_LAT 1 and 4
module tb_alu_arbiter;
  typedef struct {
    logic        port;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst4_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t        q1[$], q4[$];
  exp_t        e1, e4;
  logic [31:0] hold1[2], hold4[2];

  alu_arbiter_if if1 ();
  alu_arbiter_if if4 ();

  alu_arbiter #(.ALU_LAT(1)) u1 (.clk(clk), .rst_n(rst1_n), .bus(if1.slave));
  alu_arbiter #(.ALU_LAT(4)) u4 (.clk(clk), .rst_n(rst4_n), .bus(if4.slave));

  assign if1.alu_outpt = if1.alu_en ? if1.alu_inpt1 + if1.alu_inpt2 : 32'd0;
  assign if4.alu_outpt = if4.alu_en ? if4.alu_inpt1 + if4.alu_inpt2 : 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every vld pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if1.vld0 || if1.vld1) begin
      chk("u1_vld_overlap", 32'(if1.vld0 & if1.vld1), 32'd0);
      if (q1.size() == 0) begin
        chk("u1_unexpected_vld", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("u1_vld_port", 32'(if1.vld1), 32'(e1.port));
        chk("u1_res", e1.port ? if1.res1 : if1.res0, e1.res);
        chk("u1_vld_cycle", 32'(cyc), 32'(e1.cyc));
        chk("u1_res_hold", e1.port ? if1.res0 : if1.res1, hold1[!e1.port]);
        hold1[e1.port] = e1.res;
      end
    end
  end

  always @(negedge clk) begin
    if (if4.vld0 || if4.vld1) begin
      chk("u4_vld_overlap", 32'(if4.vld0 & if4.vld1), 32'd0);
      if (q4.size() == 0) begin
        chk("u4_unexpected_vld", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("u4_vld_port", 32'(if4.vld1), 32'(e4.port));
        chk("u4_res", e4.port ? if4.res1 : if4.res0, e4.res);
        chk("u4_vld_cycle", 32'(cyc), 32'(e4.cyc));
        chk("u4_res_hold", e4.port ? if4.res0 : if4.res1, hold4[!e4.port]);
        hold4[e4.port] = e4.res;
      end
    end
  end

  task automatic push1(input logic port, input logic [31:0] res, input int lat);
    exp_t e;
    e.port = port; e.res = res; e.cyc = cyc + lat + 1;
    q1.push_back(e);
  endtask

  task automatic push4(input logic port, input logic [31:0] res);
    exp_t e;
    e.port = port; e.res = res; e.cyc = cyc + 5;
    q4.push_back(e);
  endtask

  task automatic reset_u1();
    rst1_n = 1'b0;
    q1.delete();
    hold1[0] = 32'd0; hold1[1] = 32'd0;
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int n;
    logic exp_port;
    int g1cnt;

    {if1.req0, if1.req1, if4.req0, if4.req1} = 4'b0;
    if1.op0 = 6'd0; if1.op1 = 6'd0; if1.a0 = 32'd0; if1.a1 = 32'd0; if1.b0 = 32'd0; if1.b1 = 32'd0;
    if4.op0 = 6'd0; if4.op1 = 6'd0; if4.a0 = 32'd0; if4.a1 = 32'd0; if4.b0 = 32'd0; if4.b1 = 32'd0;
    hold1[0] = 32'd0; hold1[1] = 32'd0; hold4[0] = 32'd0; hold4[1] = 32'd0;
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    rst4_n = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_busy", 32'(if1.busy), 32'd0);
    chk("rst_alu_en", 32'(if1.alu_en), 32'd0);
    chk("rst_alu_op", 32'(if1.alu_op), 32'd0);
    chk("rst_inpt1", if1.alu_inpt1, 32'd0);
    chk("rst_inpt2", if1.alu_inpt2, 32'd0);
    chk("rst_res0", if1.res0, 32'd0);
    chk("rst_res1", if1.res1, 32'd0);
    chk("rst_vld", 32'({if1.vld0, if1.vld1}), 32'd0);
    chk("rst_gnt", 32'({if1.gnt0, if1.gnt1}), 32'd0);

    // Single request, ALU_LAT = 1
    if1.req0 = 1'b1; if1.op0 = 6'b011000; if1.a0 = 32'd2; if1.b0 = 32'd5;
    #1;
    chk("single_gnt0", 32'(if1.gnt0), 32'd1);
    chk("single_gnt1", 32'(if1.gnt1), 32'd0);
    push1(1'b0, 32'd7, 1);
    @(negedge clk);
    if1.req0 = 1'b0;
    chk("single_alu_en", 32'(if1.alu_en), 32'd1);
    chk("single_alu_op", 32'(if1.alu_op), 32'b011000);
    chk("single_busy", 32'(if1.busy), 32'd1);
    repeat (2) @(negedge clk);

    // Simultaneous requests after reset
    reset_u1();
    @(negedge clk);
    if1.req0 = 1'b1; if1.op0 = 6'b011001; if1.a0 = 32'd2;  if1.b0 = 32'd5;
    if1.req1 = 1'b1; if1.op1 = 6'b011010; if1.a1 = 32'd10; if1.b1 = 32'd3;
    #1;
    chk("tie_gnt0", 32'(if1.gnt0), 32'd1);
    chk("tie_gnt1", 32'(if1.gnt1), 32'd0);
    push1(1'b0, 32'd7, 1);
    @(negedge clk);
    if1.req0 = 1'b0;
    #1;
    chk("exec_ignores_req1", 32'(if1.gnt1), 32'd0);
    @(negedge clk);
    #1;
    chk("tie_gnt1_in_vld_cycle", 32'(if1.gnt1), 32'd1);
    push1(1'b1, 32'd13, 1);
    @(negedge clk);
    if1.req1 = 1'b0;

    // Continuous contention, 6 operations
    @(negedge clk);
    if1.a0 = 32'd1;  if1.b0 = 32'd2;
    if1.a1 = 32'd20; if1.b1 = 32'd4;
    if1.req0 = 1'b1; if1.req1 = 1'b1;
    n = 0;
    exp_port = 1'b0;
    for (int i = 0; i < 30 && n < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (if1.gnt0 || if1.gnt1) begin
        chk("cont_gnt_port", 32'(if1.gnt1), 32'(exp_port));
        chk("cont_gnt_onehot", 32'(if1.gnt0 & if1.gnt1), 32'd0);
        push1(if1.gnt1, if1.gnt1 ? 32'd24 : 32'd3, 1);
        exp_port = !exp_port;
        n++;
      end
    end
    chk("cont_grant_count", 32'(n), 32'd6);
    @(negedge clk);
    if1.req0 = 1'b0; if1.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // ALU_LAT = 4 latency
    if4.req1 = 1'b1; if4.op1 = 6'b011011; if4.a1 = 32'd100; if4.b1 = 32'd1;
    #1;
    chk("lat4_gnt1", 32'(if4.gnt1), 32'd1);
    push4(1'b1, 32'd101);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) if4.req1 = 1'b0;
      chk("lat4_busy", 32'(if4.busy), 32'd1);
    end
    @(negedge clk);
    chk("lat4_busy_end", 32'(if4.busy), 32'd0);

    // Request withdrawn before its grant
    @(negedge clk);
    if4.req0 = 1'b1; if4.a0 = 32'd7; if4.b0 = 32'd8;
    #1;
    chk("wd_gnt0", 32'(if4.gnt0), 32'd1);
    push4(1'b0, 32'd15);
    @(negedge clk);
    if4.req0 = 1'b0;
    if4.req1 = 1'b1;
    #1;
    chk("wd_exec_no_gnt1", 32'(if4.gnt1), 32'd0);
    @(negedge clk);
    if4.req1 = 1'b0;
    g1cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (if4.gnt1) g1cnt++;
    end
    chk("wd_never_granted", 32'(g1cnt), 32'd0);

    // Reset mid-EXEC discards the operation
    @(negedge clk);
    if4.req0 = 1'b1; if4.a0 = 32'd1; if4.b0 = 32'd1;
    #1;
    chk("midrst_gnt0", 32'(if4.gnt0), 32'd1);
    @(negedge clk);
    if4.req0 = 1'b0;
    chk("midrst_busy_before", 32'(if4.busy), 32'd1);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("midrst_busy_drop", 32'(if4.busy), 32'd0);
    chk("midrst_alu_en_drop", 32'(if4.alu_en), 32'd0);
    hold4[0] = 32'd0; hold4[1] = 32'd0;
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_res0_cleared", if4.res0, 32'd0);

    chk("u1_queue_drained", 32'(q1.size()), 32'd0);
    chk("u4_queue_drained", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: port 0 (MIPS execute stage) and port 1 (DSP peripheral block).
- Grants the ALU round-robin and registers the selected opcode and operands.
- Drives the ALU for a fixed number of cycles, then returns the registered result to the granted requester with a one-cycle valid pulse.
- Sits between the core/peripheral request logic and the ALU instance; it does not interpret opcodes.

## Interface
Parameters:
- ALU_LAT, 1, cycles operands are held on the ALU before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request from port 0 / port 1; level, held until the matching grant.
- op0 / op1  in  6  ALU opcode for port 0 / port 1; stable while the matching request is high.
- a0 / a1  in  32  first operand (to ALU inpt1).
- b0 / b1  in  32  second operand (to ALU inpt2).
- gnt0 / gnt1  out  1  grant; combinational; high for one cycle when the request is accepted.
- res0 / res1  out  32  last result for that port; held until that port's next completion.
- vld0 / vld1  out  1  one-cycle pulse; resN is new this cycle.
- busy  out  1  high while in EXEC.
- alu_op  out  6  to ALU Op_Code.
- alu_inpt1 / alu_inpt2  out  32  to ALU inpt1 / inpt2.
- alu_en  out  1  to ALU En.
- alu_outpt  in  32  from ALU outpt.

## Operation
- **FSM states:** IDLE, EXEC.
- **Round-robin pointer** `last` (1 bit) records the most recently granted port. Reset value is 1, so port 0 wins the first tie.
- **IDLE:**
  - Only req0 high → gnt0 = 1.
  - Only req1 high → gnt1 = 1.
  - Both high → grant port `!last`.
  - On a grant: at the edge, op/a/b of the granted port are registered into alu_op/alu_inpt1/alu_inpt2, `owner` is set to the granted port, `last` is set to the granted port, cnt is loaded with ALU_LAT-1, and the FSM moves to EXEC.
  - No request → stay in IDLE, no grant.
- **EXEC:**
  - alu_en = 1 and busy = 1; gnt0 = gnt1 = 0 regardless of requests.
  - cnt ≠ 0: decrement cnt.
  - cnt = 0: at the edge, res[owner] ← alu_outpt, vld[owner] ← 1 (registered, visible next cycle), FSM → IDLE.
- **Outside EXEC:** alu_en = 0; alu_op/alu_inpt1/alu_inpt2 keep their last registered values.
- **Valid pulses:** vld0/vld1 are 1 for exactly one cycle. Both are never high together.
- **Result hold:** the res of the non-owner port is unchanged.
- **Opcode pass-through:** opcodes are passed unmodified. Arithmetic width is entirely the ALU's; the arbiter stores 32 bits verbatim.
- **Requester contract:** a request dropped before its grant is simply not served; no error is raised.
- **Reset** (any time, including mid-EXEC):
  - FSM = IDLE, cnt = 0, `last` = 1, owner = 0.
  - alu_op = 0, alu_inpt1 = alu_inpt2 = 0, alu_en = 0, busy = 0.
  - res0 = res1 = 0, vld0 = vld1 = 0.
  - An in-flight operation is discarded; no vld is issued for it.

## Timing
- Request seen in IDLE at cycle t:
  - gnt at cycle t.
  - EXEC during cycles t+1 .. t+ALU_LAT.
  - vld and res valid at cycle t+ALU_LAT+1.
- The vld cycle is an IDLE cycle, so a new grant may occur in the same cycle.
- Sustained throughput: one operation per ALU_LAT+1 cycles.
- With both ports requesting continuously, grants alternate 0, 1, 0, 1, …
- A request raised during EXEC is first considered in the IDLE cycle after EXEC. In that cycle `last` already reflects the just-completed owner.
- gnt is combinational from req, state and `last`; every other output is registered.

## Test plan
Bench uses an ALU stub with alu_outpt = alu_inpt1 + alu_inpt2 when alu_en = 1, and 0 otherwise.
- **Reset values:** rst_n low then high → all outputs 0, busy = 0. Assert rst_n low mid-EXEC → busy drops immediately and no vld follows.
- **Single request, ALU_LAT = 1:** req0 with op0 = 6'b011000, a0 = 2, b0 = 5 → gnt0 at t; alu_en = 1 and alu_op = 011000 at t+1; vld0 = 1 and res0 = 7 at t+2; res1 stays 0.
- **Simultaneous requests after reset:** req0 (a0 = 2, b0 = 5, op0 = 011001) and req1 (a1 = 10, b1 = 3, op1 = 011010) → gnt0 first, res0 = 7. Then gnt1 in the vld0 cycle, and res1 = 13 two cycles later.
- **Continuous contention, 6 operations:** both ports request continuously → grant order 0, 1, 0, 1, 0, 1; vld pulses never overlap; each vld is exactly one cycle wide.
- **ALU_LAT = 4 latency:** req1 with op1 = 6'b011011, a1 = 100, b1 = 1 → busy high for 4 cycles; vld1 at t+5 with res1 = 101.
- **Requests ignored during EXEC:** raise req0 during EXEC → no gnt until FSM returns to IDLE.
- **Request withdrawn:** drop req1 before its grant → it is never granted and no vld1 occurs.
